// File: rtl/square_pkg.sv
// Shared types and defaults for the square sprite controller: command opcodes,
// FSM states, default screen/sprite geometry and velocity negation helper.
package square_pkg;

    typedef enum logic [1:0] {
        OP_SET_POS  = 2'b00,
        OP_SET_CTRL = 2'b01,
        OP_SET_VEL  = 2'b10,
        OP_FILL     = 2'b11
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int SIZE_DEF  = 16;

    // -8 has no positive 4-bit counterpart, so it bounces back as +7.
    function automatic logic [3:0] neg_sat(input logic [3:0] v);
        return (v == 4'b1000) ? 4'b0111 : (~v + 4'd1);
    endfunction

endpackage

// File: rtl/square_axis.sv
// One axis of sprite motion: position step by a signed 4-bit velocity with
// bounce at 0 and LIM. Purely combinational; the caller registers the result.
module square_axis
    import square_pkg::*;
#(
    parameter int LIM = H_RES_DEF - SIZE_DEF
) (
    input  logic [10:0] p,
    input  logic [3:0]  v,
    output logic [10:0] p_next,
    output logic [3:0]  v_next
);

    localparam logic signed [11:0] LIM_S = 12'(LIM);

    logic signed [11:0] sum;

    assign sum = $signed({1'b0, p}) + $signed({{8{v[3]}}, v});

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        p_next = sum[10:0];
        v_next = v;
        if (sum > LIM_S) begin
            p_next = LIM_S[10:0];
            v_next = neg_sat(v);
        end else if (sum < 12'sd0) begin
            p_next = 11'd0;
            v_next = neg_sat(v);
        end
    end

endmodule

// File: rtl/square_ctrl.sv
// Square sprite controller: command decode, sprite RAM fill sequencer and,
// when SQUARE_CTRL_MOTION_EN is defined, a per-frame bouncing motion engine.
module square_ctrl
    import square_pkg::*;
#(
    parameter int ADDR  = 10,
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF,
    parameter int SIZE  = SIZE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [10:0]     x,
    input  logic [10:0]     y,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [31:0]     cmd_data,
    output logic [10:0]     x0,
    output logic [10:0]     y0,
    output logic [4:0]      ctrl,
    output logic            we,
    output logic [ADDR-1:0] addr_w,
    output logic [1:0]      pixel_in,
    output logic            busy,
    output logic            fill_done
);

    localparam int LIM_X = H_RES - SIZE;
    localparam int LIM_Y = V_RES - SIZE;

    state_e     state;
    logic [7:0] cnt;
    logic [1:0] sid;
    logic       fire;
    op_e        op;

    assign fire = cmd_valid && cmd_ready;
    assign op   = op_e'(cmd_op);

`ifdef SQUARE_CTRL_MOTION_EN
    logic [3:0]  vx, vy, vx_nx, vy_nx;
    logic        move_en;
    logic [10:0] x_d1, x_nx, y_nx;
    logic        frame_tick, motion_step;

    assign frame_tick  = (x_d1 == 11'd0) && (x == 11'd1) && (y == 11'd0);
    // Position/velocity commands take priority over the frame's motion step.
    assign motion_step = frame_tick && move_en &&
                         !(fire && (op == OP_SET_POS || op == OP_SET_VEL));

    square_axis #(.LIM(LIM_X)) u_axis_x (.p(x0), .v(vx), .p_next(x_nx), .v_next(vx_nx));
    square_axis #(.LIM(LIM_Y)) u_axis_y (.p(y0), .v(vy), .p_next(y_nx), .v_next(vy_nx));

    logic unused;
    assign unused = ^cmd_data[31:22];
`else
    logic unused;
    assign unused = ^{x, y, cmd_data[31:22]} ^ (LIM_X > LIM_Y);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            x0        <= '0;
            y0        <= '0;
            ctrl      <= '0;
            we        <= 1'b0;
            addr_w    <= '0;
            pixel_in  <= '0;
            busy      <= 1'b0;
            fill_done <= 1'b0;
            cnt       <= '0;
            sid       <= '0;
`ifdef SQUARE_CTRL_MOTION_EN
            vx        <= '0;
            vy        <= '0;
            move_en   <= 1'b0;
            x_d1      <= '0;
`endif
        end else begin
            fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        case (op)
                            OP_SET_POS: begin
                                x0 <= cmd_data[10:0];
                                y0 <= cmd_data[21:11];
                            end
                            OP_SET_CTRL: ctrl <= cmd_data[4:0];
                            OP_SET_VEL: begin
`ifdef SQUARE_CTRL_MOTION_EN
                                vx      <= cmd_data[3:0];
                                vy      <= cmd_data[7:4];
                                move_en <= cmd_data[8];
`endif
                            end
                            OP_FILL: begin
                                state     <= FILL;
                                cmd_ready <= 1'b0;
                                busy      <= 1'b1;
                                we        <= 1'b1;
                                sid       <= cmd_data[1:0];
                                cnt       <= 8'd0;
                                addr_w    <= ADDR'({cmd_data[1:0], 8'd0});
                                pixel_in  <= cmd_data[3:2];
                            end
                        endcase
                    end
                end
                FILL: begin
                    if (cnt == 8'hFF) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        we        <= 1'b0;
                        fill_done <= 1'b1;
                    end else begin
                        cnt    <= cnt + 8'd1;
                        addr_w <= ADDR'({sid, cnt + 8'd1});
                    end
                end
            endcase
`ifdef SQUARE_CTRL_MOTION_EN
            x_d1 <= x;
            if (motion_step) begin
                x0 <= x_nx;
                y0 <= y_nx;
                vx <= vx_nx;
                vy <= vy_nx;
            end
`endif
        end
    end

endmodule

// File: tb/tb_square_ctrl.sv
// Self-checking bench for square_ctrl; motion checks apply when
// SQUARE_CTRL_MOTION_EN is defined, otherwise SET_VEL must be a no-op.
module tb_square_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = 11'd5, y = 11'd5;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_data = '0;
    logic [10:0] x0, y0;
    logic [4:0]  ctrl;
    logic        we;
    logic [9:0]  addr_w;
    logic [1:0]  pixel_in;
    logic        busy, fill_done;

    square_ctrl dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .x0(x0), .y0(y0), .ctrl(ctrl), .we(we), .addr_w(addr_w), .pixel_in(pixel_in),
        .busy(busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic [1:0] pix;
    } wr_t;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] data);
        int n = 0;
        while (!cmd_ready && n < 1000) begin
            step();
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic push_fill(input logic [1:0] s, input logic [1:0] c);
        for (int i = 0; i < 256; i++) sb.push_back({s, 8'(i), c});
    endtask

    task automatic tick();
        x = 11'd0; y = 11'd0;
        step();
        x = 11'd1;
        step();
        x = 11'd5; y = 11'd5;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] pos(input int px, input int py);
        return 32'((py << 11) | px);
    endfunction

    // Write monitor: every RAM write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (fill_done) done_cnt++;
            if (we) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    check("wr_unexpected", {22'd0, addr_w}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", {22'd0, addr_w}, {22'd0, e.addr});
                    check("wr_pix", {30'd0, pixel_in}, {30'd0, e.pix});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_x0", 32'(x0), 32'd0);
        check("rst_y0", 32'(y0), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(fill_done), 32'd0);
        check("rst_addr", 32'(addr_w), 32'd0);

        send(2'b00, pos(100, 50));
        check("pos_x0", 32'(x0), 32'd100);
        check("pos_y0", 32'(y0), 32'd50);
        check("pos_ready", 32'(cmd_ready), 32'd1);

        send(2'b01, 32'h0000_0015);
        check("ctrl_val", 32'(ctrl), 32'h15);

        // FILL sid=2 code=2: 256 writes at 0x200..0x2FF.
        w0 = wr_cnt;
        d0 = done_cnt;
        push_fill(2'd2, 2'd2);
        send(2'b11, 32'h0000_000A);
        for (int i = 0; i < 256; i++) begin
            if (cmd_ready !== 1'b0 || busy !== 1'b1) check("fill_ready_busy", {cmd_ready, busy}, 32'b01);
            if (i == 0) check("fill_first_addr", 32'(addr_w), 32'h200);
            if (i == 255) check("fill_last_addr", 32'(addr_w), 32'h2FF);
            step();
        end
        check("fill_end_we", 32'(we), 32'd0);
        check("fill_end_busy", 32'(busy), 32'd0);
        check("fill_end_done", 32'(fill_done), 32'd1);
        check("fill_end_ready", 32'(cmd_ready), 32'd1);
        step();
        check("fill_done_pulse", 32'(fill_done), 32'd0);
        check("fill_wr_count", 32'(wr_cnt - w0), 32'd256);
        check("fill_done_count", 32'(done_cnt - d0), 32'd1);
        check("fill_sb_empty", 32'(sb.size()), 32'd0);

`ifdef SQUARE_CTRL_MOTION_EN
        // Right-edge bounce: 620+7 -> 624, then 624-7 -> 617.
        send(2'b00, pos(620, 100));
        send(2'b10, 32'h0000_0107);
        tick();
        check("bounce_r_x0", 32'(x0), 32'd624);
        check("bounce_r_y0", 32'(y0), 32'd100);
        tick();
        check("bounce_r_x0_2", 32'(x0), 32'd617);

        // Left-edge bounce: 3-5 -> 0, then +5.
        send(2'b00, pos(3, 100));
        send(2'b10, 32'h0000_010B);
        tick();
        check("bounce_l_x0", 32'(x0), 32'd0);
        tick();
        check("bounce_l_x0_2", 32'(x0), 32'd5);

        // -8 negates to +7.
        send(2'b00, pos(3, 100));
        send(2'b10, 32'h0000_0108);
        tick();
        check("sat_x0", 32'(x0), 32'd0);
        tick();
        check("sat_x0_2", 32'(x0), 32'd7);

        // Bottom-edge bounce on y: 470+7 -> 464, then 457.
        send(2'b00, pos(10, 470));
        send(2'b10, 32'h0000_0170);
        tick();
        check("bounce_b_y0", 32'(y0), 32'd464);
        check("bounce_b_x0", 32'(x0), 32'd10);
        tick();
        check("bounce_b_y0_2", 32'(y0), 32'd457);

        // SET_POS coincident with frame_tick wins; motion resumes next frame.
        send(2'b00, pos(200, 100));
        send(2'b10, 32'h0000_0105);
        x = 11'd0; y = 11'd0;
        step();
        x = 11'd1;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = pos(300, 100);
        step();
        cmd_valid = 1'b0;
        x = 11'd5; y = 11'd5;
        check("coinc_x0", 32'(x0), 32'd300);
        tick();
        check("coinc_next_x0", 32'(x0), 32'd305);

        // Motion continues during a fill.
        push_fill(2'd0, 2'd1);
        send(2'b11, 32'h0000_0004);
        tick();
        check("fill_motion_busy", 32'(busy), 32'd1);
        check("fill_motion_x0", 32'(x0), 32'd310);
        wait_idle();

        // move_en=0 freezes the sprite.
        send(2'b10, 32'h0000_0005);
        tick();
        check("frozen_x0", 32'(x0), 32'd310);
`else
        send(2'b10, 32'h0000_0107);
        check("vel_ready", 32'(cmd_ready), 32'd1);
        tick();
        check("vel_ignored_x0", 32'(x0), 32'd100);
        check("vel_ignored_y0", 32'(y0), 32'd50);
`endif

        // Reset at write 100 aborts the fill with no completion pulse.
        push_fill(2'd1, 2'd3);
        send(2'b11, 32'h0000_000D);
        repeat (100) step();
        check("abort_addr", 32'(addr_w), 32'h164);
        reset = 1'b1;
        step();
        check("abort_we", 32'(we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        sb.delete();
        d0 = done_cnt;
        repeat (300) step();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_idle_we", 32'(we), 32'd0);
        check("abort_x0", 32'(x0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
